mac_operand_sequencer: RTL and testbench

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

---
 rtl/mac_operand_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Streams operand pairs for a MAC array. A tile of TILE_ROWS A rows is
//   preloaded into a shadow register, then the B rows are streamed one per
//   cycle. While the current tile is in use, the next A tile is prefetched
//   into the shadow and swapped into a_vec on the first B row of each tile.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start, abort, hold         job request (IDLE only), job cancel, read stall
//   cfg_int8/int4/vsq          mode flags, latched at start
//   a_rd_en/addr/data          A SRAM read port (data one cycle after strobe)
//   b_rd_en/addr/data          B SRAM read port (data one cycle after strobe)
//   a_vec                      current A tile, row 0 in the MSBs
//   b_vec                      current B row
//   valid, last                operand pair valid / final row of the job
//   is_int8_mode/int4/is_vsq   latched mode flags
//   busy                       high in every state except IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// PRELOAD | reading A rows 0..TILE_ROWS-1 into the shadow tile
// STREAM  | reading B rows 0..NUM_ROWS-1, prefetching the next A tile
// DRAIN   | reads done, waiting for the last B row to be delivered
module mac_operand_sequencer #(
    parameter int ROW_W     = 264,
    parameter int TILE_ROWS = 16,
    parameter int NUM_ROWS  = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          hold,
    input  logic                          cfg_int8,
    input  logic                          cfg_int4,
    input  logic                          cfg_vsq,
    output logic                          a_rd_en,
    output logic [ADDR_W-1:0]             a_rd_addr,
    input  logic [ROW_W-1:0]              a_rd_data,
    output logic                          b_rd_en,
    output logic [ADDR_W-1:0]             b_rd_addr,
    input  logic [ROW_W-1:0]              b_rd_data,
    output logic [TILE_ROWS*ROW_W-1:0]    a_vec,
    output logic [ROW_W-1:0]              b_vec,
    output logic                          valid,
    output logic                          last,
    output logic                          is_int8_mode,
    output logic                          is_int4_mode,
    output logic                          is_vsq,
    output logic                          busy
);

    localparam int JW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, PRELOAD, STREAM, DRAIN} state_t;

    state_t                       state;
    logic [JW-1:0]                j_cnt;
    logic [ADDR_W-1:0]            k_cnt;
    logic [JW-1:0]                a_rd_row;
    logic                         b_rd_first;
    logic                         a_pend;
    logic [JW-1:0]                a_pend_row;
    logic                         b_pend;
    logic                         b_pend_first;
    logic                         b_pend_last;
    logic [TILE_ROWS*ROW_W-1:0]   shadow;

    // Prefetch address for the B read at index k is simply k + TILE_ROWS;
    // it is only legal while that still lands inside the job.
    logic [ADDR_W:0]              pf_sum;
    logic                         pf_ok;
    logic                         pre_go;
    logic [JW-1:0]                pre_j;

    assign pf_sum = {1'b0, k_cnt} + (ADDR_W+1)'(TILE_ROWS);
    assign pf_ok  = pf_sum < (ADDR_W+1)'(NUM_ROWS);
    assign busy   = (state != IDLE);

    // The first preload read is issued on the start edge itself so the
    // read strobe is already high in the first cycle of the job.
    always_comb begin
        pre_go = 1'b0;
        pre_j  = j_cnt;
        if (state == IDLE) begin
            pre_j  = '0;
            pre_go = start && !abort && !hold;
        end else if (state == PRELOAD) begin
            pre_go = !hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            j_cnt        <= '0;
            k_cnt        <= '0;
            a_rd_en      <= 1'b0;
            a_rd_addr    <= '0;
            a_rd_row     <= '0;
            b_rd_en      <= 1'b0;
            b_rd_addr    <= '0;
            b_rd_first   <= 1'b0;
            a_pend       <= 1'b0;
            a_pend_row   <= '0;
            b_pend       <= 1'b0;
            b_pend_first <= 1'b0;
            b_pend_last  <= 1'b0;
            shadow       <= '0;
            a_vec        <= '0;
            b_vec        <= '0;
            valid        <= 1'b0;
            last         <= 1'b0;
            is_int8_mode <= 1'b0;
            is_int4_mode <= 1'b0;
            is_vsq       <= 1'b0;
        end else begin
            a_rd_en <= 1'b0;
            b_rd_en <= 1'b0;
            if (abort && state != IDLE) begin
                // Drop everything in flight; operand and mode registers keep
                // their last values.
                state  <= IDLE;
                a_pend <= 1'b0;
                b_pend <= 1'b0;
                valid  <= 1'b0;
                last   <= 1'b0;
            end else begin
                a_pend       <= a_rd_en;
                a_pend_row   <= a_rd_row;
                b_pend       <= b_rd_en;
                b_pend_first <= b_rd_first;
                b_pend_last  <= (b_rd_addr == ADDR_W'(NUM_ROWS-1));

                if (a_pend)
                    shadow[(TILE_ROWS-1-int'(a_pend_row))*ROW_W +: ROW_W] <= a_rd_data;

                valid <= b_pend;
                last  <= b_pend && b_pend_last;
                if (b_pend) begin
                    b_vec <= b_rd_data;
                    // Non-blocking read of shadow: a same-edge shadow write
                    // belongs to the next tile and must not leak in.
                    if (b_pend_first)
                        a_vec <= shadow;
                end

                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            is_int8_mode <= cfg_int8;
                            is_int4_mode <= cfg_int4;
                            is_vsq       <= cfg_vsq;
                            j_cnt        <= '0;
                            k_cnt        <= '0;
                            state        <= PRELOAD;
                        end
                    end
                    PRELOAD: ;
                    STREAM: begin
                        if (!hold) begin
                            b_rd_en    <= 1'b1;
                            b_rd_addr  <= k_cnt;
                            b_rd_first <= (j_cnt == '0);
                            if (pf_ok) begin
                                a_rd_en   <= 1'b1;
                                a_rd_addr <= pf_sum[ADDR_W-1:0];
                                a_rd_row  <= j_cnt;
                            end
                            j_cnt <= (j_cnt == JW'(TILE_ROWS-1)) ? '0 : j_cnt + JW'(1);
                            k_cnt <= k_cnt + ADDR_W'(1);
                            if (k_cnt == ADDR_W'(NUM_ROWS-1))
                                state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (valid && last)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                if (pre_go) begin
                    a_rd_en   <= 1'b1;
                    a_rd_addr <= ADDR_W'(pre_j);
                    a_rd_row  <= pre_j;
                    if (pre_j == JW'(TILE_ROWS-1)) begin
                        j_cnt <= '0;
                        state <= STREAM;
                    end else begin
                        j_cnt <= pre_j + JW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;
    localparam int ROW_W = 264;
    localparam int TR    = 16;
    localparam int NR    = 32;
    localparam int AW    = 5;
    localparam int TW    = TR*ROW_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, hold = 1'b0;
    logic cfg_int8 = 1'b0, cfg_int4 = 1'b0, cfg_vsq = 1'b0;
    logic a_rd_en, b_rd_en;
    logic [AW-1:0] a_rd_addr, b_rd_addr;
    logic [ROW_W-1:0] a_rd_data, b_rd_data, b_vec;
    logic [TW-1:0] a_vec;
    logic valid, last, is_int8_mode, is_int4_mode, is_vsq, busy;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mac_operand_sequencer #(.ROW_W(ROW_W), .TILE_ROWS(TR), .NUM_ROWS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .cfg_int8(cfg_int8), .cfg_int4(cfg_int4), .cfg_vsq(cfg_vsq),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .a_vec(a_vec), .b_vec(b_vec), .valid(valid), .last(last),
        .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq),
        .busy(busy)
    );

    // SRAM models: A row i = i, B row i = 0x100 + i; junk when not read.
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? ROW_W'(a_rd_addr) : {(ROW_W/8){8'hA5}};
        b_rd_data <= b_rd_en ? ROW_W'(b_rd_addr) + ROW_W'(32'h100) : {(ROW_W/8){8'h5A}};
    end

    function automatic logic [TW-1:0] exp_tile(input int t);
        logic [TW-1:0] v;
        v = '0;
        for (int j = 0; j < TR; j++)
            v[(TR-1-j)*ROW_W +: ROW_W] = ROW_W'(t*TR + j);
        return v;
    endfunction

    // Low byte of every row, row 0 first, for readable reports.
    function automatic logic [8*TR-1:0] fold(input logic [TW-1:0] v);
        logic [8*TR-1:0] f;
        for (int j = 0; j < TR; j++)
            f[(TR-1-j)*8 +: 8] = v[(TR-1-j)*ROW_W +: 8];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_avec(input string tag, input logic [TW-1:0] exp);
        n_total++;
        assert (a_vec === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed rows %h expected rows %h", tag, fold(a_vec), fold(exp));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, {a_rd_en, b_rd_en}, 0);
        chk({tag, "_rd_addr"}, {a_rd_addr, b_rd_addr}, 0);
        chk({tag, "_b_vec"}, b_vec, 0);
        chk_avec({tag, "_a_vec"}, '0);
        chk({tag, "_valid_last_busy"}, {valid, last, busy}, 0);
        chk({tag, "_mode"}, {is_int8_mode, is_int4_mode, is_vsq}, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job starting at the next edge (E0). hold is sampled high on edges
    // hold_at..hold_at+hold_len-1; abort is driven during cycle abort_at;
    // rst_n pulses low during cycle rst_at. Negative = not used.
    task automatic run_job(input int hold_at, input int hold_len, input int abort_at,
                           input int rst_at, input bit keep_start, input logic [2:0] cfg);
        int vcyc[NR];
        int rdidx[100];
        int r, last_v, kill, nxt_k, ri;
        logic exp_v;
        logic [2:0] exp_cfg;

        for (int e = 0; e < 100; e++) rdidx[e] = -1;
        r = 0;
        for (int e = 0; e < 100 && r < TR+NR; e++) begin
            if (!(e >= hold_at && e < hold_at + hold_len)) begin
                rdidx[e] = r;
                if (r >= TR) vcyc[r-TR] = e + 2;
                r++;
            end
        end
        last_v = vcyc[NR-1];
        kill = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : 1000);

        {cfg_int8, cfg_int4, cfg_vsq} = cfg;
        start = 1'b1;
        step();
        start = keep_start;
        {cfg_int8, cfg_int4, cfg_vsq} = ~cfg;
        nxt_k = 0;

        for (int c = 0; c <= last_v + 1; c++) begin
            ri = (c <= kill) ? rdidx[c] : -1;
            exp_v = (c <= kill) && (nxt_k < NR) && (vcyc[nxt_k] == c);
            chk("valid", valid, exp_v);
            chk("busy", busy, (c <= last_v) && (c <= kill));
            chk("a_rd_en", a_rd_en, (ri >= 0) && (ri < NR));
            if (ri >= 0 && ri < NR) chk("a_rd_addr", a_rd_addr, ri);
            chk("b_rd_en", b_rd_en, ri >= TR);
            if (ri >= TR) chk("b_rd_addr", b_rd_addr, ri - TR);
            exp_cfg = (rst_at >= 0 && c > rst_at) ? 3'b000 : cfg;
            chk("mode", {is_int8_mode, is_int4_mode, is_vsq}, exp_cfg);
            if (exp_v) begin
                chk("b_vec", b_vec, 32'h100 + nxt_k);
                chk("last", last, nxt_k == NR-1);
                chk_avec("a_vec", exp_tile(nxt_k / TR));
                nxt_k++;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                chk("b_vec_hold", b_vec, 32'h100 + nxt_k - 1);
                chk_avec("a_vec_hold", exp_tile((nxt_k - 1) / TR));
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("async_rst");
                #4;
                rst_n = 1'b1;
            end
            hold  = (c + 1 >= hold_at) && (c + 1 < hold_at + hold_len);
            abort = (c == abort_at);
            if (c != last_v + 1) step();
        end
        chk("beats", nxt_k, (kill < 1000) ? nxt_k : NR);
        hold  = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        step();

        run_job(100, 0, -1, -1, 1'b0, 3'b100);   // nominal, int8
        run_job(26, 3, -1, -1, 1'b0, 3'b100);    // stall at k=10
        run_job(2, 2, -1, -1, 1'b0, 3'b010);     // stall in preload
        run_job(100, 0, 25, -1, 1'b0, 3'b001);   // abort in cycle 25
        run_job(100, 0, -1, -1, 1'b0, 3'b100);
        run_job(100, 0, -1, 30, 1'b0, 3'b100);   // reset in cycle 30
        run_job(100, 0, -1, -1, 1'b0, 3'b100);
        run_job(100, 0, -1, -1, 1'b1, 3'b111);   // start held through job
        run_job(100, 0, -1, -1, 1'b0, 3'b100);   // its back-to-back successor

        // start together with abort in IDLE must not launch a job
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_start_busy", busy, 0);
            chk("abort_start_rd", {a_rd_en, b_rd_en}, 0);
            chk("abort_start_valid", valid, 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
